// File: rtl/tug_field.sv
// Tug-of-war playfield: one lit LED moves toward whichever player presses; pushing it off
// an edge wins. Define TUG_SCORE_EN for saturating win counters and press-to-restart.
module tug_field #(
    parameter int NLED = 9
) (
    input  logic            CLOCK,
    input  logic            Reset,
    input  logic            press_l,
    input  logic            press_r,
    output logic [NLED-1:0] led,
    output logic            win_l,
    output logic            win_r
`ifdef TUG_SCORE_EN
    ,
    output logic [2:0]      score_l,
    output logic [2:0]      score_r
`endif
);

    localparam int PW = (NLED > 1) ? $clog2(NLED) : 1;
    localparam logic [PW-1:0]   POS_CENTRE = PW'((NLED - 1) / 2);
    localparam logic [PW-1:0]   POS_LEFT   = PW'(NLED - 1);
    localparam logic [NLED-1:0] LED_CENTRE = NLED'(1) << POS_CENTRE;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        WIN_L = 2'd1,
        WIN_R = 2'd2
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   pos_q;
    logic [NLED-1:0] led_q;
    logic            win_l_q;
    logic            win_r_q;

    logic move_l;
    logic move_r;

    // Simultaneous presses cancel each other.
    assign move_l = press_l & ~press_r;
    assign move_r = press_r & ~press_l;

`ifdef TUG_SCORE_EN
    logic [2:0] score_l_q;
    logic [2:0] score_r_q;
`endif

    // NOTE: non-blocking assignments only, so every register sees pre-edge values of the others.
    always_ff @(posedge CLOCK or posedge Reset) begin
        if (Reset) begin
            state_q   <= PLAY;
            pos_q     <= POS_CENTRE;
            led_q     <= LED_CENTRE;
            win_l_q   <= 1'b0;
            win_r_q   <= 1'b0;
`ifdef TUG_SCORE_EN
            score_l_q <= 3'd0;
            score_r_q <= 3'd0;
`endif
        end else begin
            case (state_q)
                PLAY: begin
                    if (move_l) begin
                        if (pos_q == POS_LEFT) begin
                            state_q <= WIN_L;
                            led_q   <= '0;
                            win_l_q <= 1'b1;
`ifdef TUG_SCORE_EN
                            if (score_l_q != 3'd7) score_l_q <= score_l_q + 3'd1;
`endif
                        end else begin
                            pos_q <= pos_q + PW'(1);
                            led_q <= NLED'(1) << (pos_q + PW'(1));
                        end
                    end else if (move_r) begin
                        if (pos_q == '0) begin
                            state_q <= WIN_R;
                            led_q   <= '0;
                            win_r_q <= 1'b1;
`ifdef TUG_SCORE_EN
                            if (score_r_q != 3'd7) score_r_q <= score_r_q + 3'd1;
`endif
                        end else begin
                            pos_q <= pos_q - PW'(1);
                            led_q <= NLED'(1) << (pos_q - PW'(1));
                        end
                    end
                end
                WIN_L, WIN_R: begin
`ifdef TUG_SCORE_EN
                    // Any press, including a tie, starts a new round from the centre.
                    if (press_l || press_r) begin
                        state_q <= PLAY;
                        pos_q   <= POS_CENTRE;
                        led_q   <= LED_CENTRE;
                        win_l_q <= 1'b0;
                        win_r_q <= 1'b0;
                    end
`endif
                end
                default: begin
                    state_q <= PLAY;
                    pos_q   <= POS_CENTRE;
                    led_q   <= LED_CENTRE;
                    win_l_q <= 1'b0;
                    win_r_q <= 1'b0;
                end
            endcase
        end
    end

    assign led   = led_q;
    assign win_l = win_l_q;
    assign win_r = win_r_q;
`ifdef TUG_SCORE_EN
    assign score_l = score_l_q;
    assign score_r = score_r_q;
`endif

endmodule

// File: tb/tb_tug_field.sv
// Scoreboard bench for tug_field (NLED=9): the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_tug_field;

    localparam int NLED = 9;
    localparam logic [NLED-1:0] CENTRE = 9'b000010000;

    logic            CLOCK = 1'b0;
    logic            Reset = 1'b0;
    logic            press_l = 1'b0;
    logic            press_r = 1'b0;
    logic [NLED-1:0] led;
    logic            win_l;
    logic            win_r;
    logic [2:0]      score_l;
    logic [2:0]      score_r;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [NLED-1:0] led;
        logic            wl;
        logic            wr;
        logic            chk_score;
        logic [2:0]      sl;
        logic [2:0]      sr;
        string           name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    tug_field #(.NLED(NLED)) dut (
        .CLOCK   (CLOCK),
        .Reset   (Reset),
        .press_l (press_l),
        .press_r (press_r),
        .led     (led),
        .win_l   (win_l),
        .win_r   (win_r)
`ifdef TUG_SCORE_EN
        ,
        .score_l (score_l),
        .score_r (score_r)
`endif
    );

`ifndef TUG_SCORE_EN
    assign score_l = 3'd0;
    assign score_r = 3'd0;
`endif

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // Monitor: outputs are registered, so the negedge is a stable sampling point.
    always @(negedge CLOCK) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check({mon_e.name, " {led,win_l,win_r}"}, 32'({led, win_l, win_r}),
                  32'({mon_e.led, mon_e.wl, mon_e.wr}));
            check({mon_e.name, " invariant"}, 32'({$onehot0(led), ~(win_l & win_r)}), 32'b11);
`ifdef TUG_SCORE_EN
            if (mon_e.chk_score)
                check({mon_e.name, " {score_l,score_r}"}, 32'({score_l, score_r}),
                      32'({mon_e.sl, mon_e.sr}));
`endif
        end
    end

    task automatic push(input logic [NLED-1:0] el, input logic ewl, input logic ewr,
                        input string nm, input logic cs, input logic [2:0] esl,
                        input logic [2:0] esr);
        exp_t e;
        e.led = el; e.wl = ewl; e.wr = ewr;
        e.chk_score = cs; e.sl = esl; e.sr = esr; e.name = nm;
        sb_q.push_back(e);
    endtask

    // One clock of stimulus; the expectation is what the DUT shows after that edge.
    task automatic step(input logic pl, input logic pr, input logic [NLED-1:0] el,
                        input logic ewl, input logic ewr, input string nm,
                        input logic cs = 1'b0, input logic [2:0] esl = 3'd0,
                        input logic [2:0] esr = 3'd0);
        @(negedge CLOCK);
        press_l = pl;
        press_r = pr;
        @(posedge CLOCK);
        push(el, ewl, ewr, nm, cs, esl, esr);
    endtask

    // Reset is raised mid-cycle and checked before any further clock edge.
    task automatic do_reset(input string nm);
        @(posedge CLOCK);
        #2;
        press_l = 1'b0;
        press_r = 1'b0;
        Reset   = 1'b1;
        #1;
        push(CENTRE, 1'b0, 1'b0, nm, 1'b1, 3'd0, 3'd0);
        @(posedge CLOCK);
        #2;
        Reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NLED-1:0] exp_led;
        logic [2:0]      exp_sl;

        do_reset("reset_async");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, CENTRE, 1'b0, 1'b0, "idle_hold");

        // Four left pulses walk the light to the left edge, the fifth wins.
        step(1'b1, 1'b0, 9'b000100000, 1'b0, 1'b0, "left_1");
        step(1'b0, 1'b0, 9'b000100000, 1'b0, 1'b0, "left_1_hold");
        step(1'b1, 1'b0, 9'b001000000, 1'b0, 1'b0, "left_2");
        step(1'b1, 1'b0, 9'b010000000, 1'b0, 1'b0, "left_3");
        step(1'b0, 1'b0, 9'b010000000, 1'b0, 1'b0, "left_3_hold");
        step(1'b1, 1'b0, 9'b100000000, 1'b0, 1'b0, "left_4_edge");
        step(1'b1, 1'b0, 9'b000000000, 1'b1, 1'b0, "left_win");
`ifndef TUG_SCORE_EN
        step(1'b1, 1'b0, 9'b000000000, 1'b1, 1'b0, "win_l_terminal_l");
        step(1'b0, 1'b1, 9'b000000000, 1'b1, 1'b0, "win_l_terminal_r");
        step(1'b1, 1'b1, 9'b000000000, 1'b1, 1'b0, "win_l_terminal_both");
        step(1'b0, 1'b0, 9'b000000000, 1'b1, 1'b0, "win_l_terminal_idle");
`endif

        do_reset("reset_from_win_l");
        step(1'b1, 1'b1, CENTRE,       1'b0, 1'b0, "tie_cancels");
        step(1'b0, 1'b1, 9'b000001000, 1'b0, 1'b0, "right_after_tie");

        do_reset("reset_mid_game");
        step(1'b0, 1'b1, 9'b000001000, 1'b0, 1'b0, "right_1");
        step(1'b0, 1'b1, 9'b000000100, 1'b0, 1'b0, "right_2");
        step(1'b0, 1'b1, 9'b000000010, 1'b0, 1'b0, "right_3");
        step(1'b0, 1'b1, 9'b000000001, 1'b0, 1'b0, "right_4_edge");
        step(1'b0, 1'b1, 9'b000000000, 1'b0, 1'b1, "right_win");
        step(1'b0, 1'b0, 9'b000000000, 1'b0, 1'b1, "right_win_hold");
        do_reset("reset_from_win_r");
        step(1'b0, 1'b0, CENTRE,       1'b0, 1'b0, "after_reset_win_r");

        // A held press counts once per cycle and must never wrap to the other edge.
`ifndef TUG_SCORE_EN
        for (int i = 0; i < 10; i++) begin
`else
        for (int i = 0; i < 5; i++) begin
`endif
            exp_led = (i < 4) ? (NLED'(1) << (5 + i)) : '0;
            step(1'b1, 1'b0, exp_led, (i >= 4), 1'b0, $sformatf("held_left_%0d", i));
        end
        step(1'b0, 1'b0, (NLED'(1) << 4) & '0, 1'b1, 1'b0, "held_left_release");

`ifdef TUG_SCORE_EN
        do_reset("reset_before_scoring");
        for (int r = 0; r < 8; r++) begin
            exp_sl = (r >= 6) ? 3'd7 : 3'(r + 1);
            for (int i = 0; i < 4; i++)
                step(1'b1, 1'b0, NLED'(1) << (5 + i), 1'b0, 1'b0, $sformatf("round%0d_step%0d", r, i));
            step(1'b1, 1'b0, '0, 1'b1, 1'b0, $sformatf("round%0d_win", r), 1'b1, exp_sl, 3'd0);
            step(1'b0, 1'b1, CENTRE, 1'b0, 1'b0, $sformatf("round%0d_restart", r), 1'b1, exp_sl, 3'd0);
        end
        step(1'b0, 1'b1, 9'b000001000, 1'b0, 1'b0, "after_restart_play", 1'b1, 3'd7, 3'd0);
        do_reset("reset_clears_scores");
`endif

        @(negedge CLOCK);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
